input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Two-channel synchronizer and debouncer for slow, noisy external inputs (switches, buttons).
- Sits directly upstream of example_and_gate: deb_1/deb_2 drive its input_1/input_2.
- Guarantees the gate only ever sees clean, clock-aligned, glitch-free levels.
- Also emits a one-cycle change pulse so a downstream consumer can sample the gate output only when an input changes.

Parameters:
CNT_MAX, 4, synchronized cycles an input must hold a new level before deb_x follows; legal range >= 1
SYNC_STAGES, 2, flip-flops in each input synchronizer chain; legal range >= 2

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
raw_1  input  1  asynchronous noisy input, channel 1
raw_2  input  1  asynchronous noisy input, channel 2
deb_1  output  1  debounced level, channel 1 (drives input_1)
deb_2  output  1  debounced level, channel 2 (drives input_2)
chg  output  1  one-cycle pulse when deb_1 or deb_2 changed on this edge
busy  output  1  high while either channel holds a pending, not-yet-accepted level

Behaviour:
- Reset:
  - rst_n is sampled only on the rising edge of clk.
  - While rst_n=0, every register clears on each edge: synchronizer flops, counters, deb_1, deb_2 and chg all go to 0.
  - busy is therefore 0 one edge into reset and stays 0 while reset is held.
  - Asserting reset mid-debounce discards the pending count. There is no partial carry-over after release.
- Synchronizer:
  - Per channel, a SYNC_STAGES-deep shift register samples raw_x every edge.
  - sync_x is the last stage.
- Counter:
  - Per channel, width $clog2(CNT_MAX+1).
  - If sync_x == deb_x: cnt_x <= 0.
  - If sync_x != deb_x and cnt_x < CNT_MAX-1: cnt_x <= cnt_x+1.
  - If sync_x != deb_x and cnt_x == CNT_MAX-1: deb_x <= sync_x and cnt_x <= 0.
  - With CNT_MAX=1, deb_x updates on the first mismatching edge.
  - The counter never exceeds CNT_MAX-1, so no wrap-around is possible.
- Glitch rejection:
  - If sync_x returns to deb_x before the count completes, cnt_x clears and deb_x is unchanged.
  - A pulse lasting fewer than CNT_MAX synchronized cycles never reaches the output.
- Latency:
  - Count the edge that first samples a new, stable raw_x level as edge 1.
  - deb_x takes the new value on edge SYNC_STAGES+CNT_MAX.
  - This is edge 6 at default parameters.
- chg:
  - Registered; high for exactly one cycle, coincident with the first cycle deb_x shows its new value.
  - If both channels update on the same edge, chg pulses once, not twice.
  - Back-to-back accepted changes on different edges produce separate pulses.
- busy:
  - Combinational: (sync_1 != deb_1) | (sync_2 != deb_2).
  - No other output is combinational.
- Channel independence: channels share nothing but clk and rst_n. Activity on one channel never alters the other channel's counter.
- Stuck inputs: a raw input that never changes leaves its deb_x at its last accepted value indefinitely.

Optional Feature:
Macro: DEBOUNCE_LOCKOUT_EN
- Defined:
  - After deb_x updates, that channel enters a lockout of CNT_MAX cycles.
  - During lockout, cnt_x is held at 0 and mismatches are ignored.
  - busy still reflects mismatch.
  - Counting resumes on the first edge after lockout ends.
  - Reset clears lockout.
  - Each channel has an independent lockout counter.
- Undefined:
  - No lockout logic is synthesized.
  - Behaviour is exactly as above: a new mismatch may start counting on the edge immediately after an update.

Test Plan:
1. Reset: rst_n=0 for 3 edges with raw_1=raw_2=1 -> deb_1=deb_2=chg=busy=0. After release, deb_1 and deb_2 go to 1 on edge 6, with chg=1 for that single cycle.
2. Clean step: from deb_1=0, set raw_1=1 and hold -> busy rises after edge 2, deb_1=1 on edge 6, chg pulses once, busy=0 after edge 6. deb_2 stays 0 throughout.
3. Glitch: raw_2 pulses 1 for 3 clock cycles, then returns to 0 -> deb_2 stays 0, chg never asserts, counter returns to 0. Repeat with 4 cycles -> deb_2 rises to 1.
4. Simultaneous: raw_1 and raw_2 both rise on the same edge -> both deb outputs rise on edge 6 and chg is high for exactly 1 cycle.
5. Reset mid-count: raw_1 rises, then rst_n=0 on edge 4 for 1 edge, raw_1 held 1 -> deb_1=0 during reset. After release, deb_1 rises 6 edges after release, not sooner.
6. Lockout (DEBOUNCE_LOCKOUT_EN defined): deb_1 rises, then raw_1 drops immediately -> deb_1 falls no earlier than 4+4 cycles after the rise. Without the macro, deb_1 falls exactly 6 edges after the raw_1 drop.

Source files
------------

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
// Two-channel synchronizer + debouncer for slow, noisy external inputs.
// Each raw input passes through a SYNC_STAGES-deep synchronizer. deb_x follows
// the synchronized level only after that level has differed from deb_x for
// CNT_MAX consecutive cycles. chg pulses for one cycle on any accepted change.
// busy is the only combinational output.
//
// Optional feature macro: DEBOUNCE_LOCKOUT_EN
//   When defined, a channel ignores mismatches for CNT_MAX cycles after each
//   accepted change. Reset clears the lockout.
// ---------------------------------------------------------------------------
module input_debouncer #(
    parameter int unsigned CNT_MAX     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_1,
    input  logic raw_2,
    output logic deb_1,
    output logic deb_2,
    output logic chg,
    output logic busy
);

    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [NCH-1:0] raw_c;
    logic [NCH-1:0] sync_c;
    logic [NCH-1:0] deb_c;
    logic [NCH-1:0] upd_c;
    logic           chg_q;
    logic           chg_d;

    assign raw_c = {raw_2, raw_1};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;
        logic [CW-1:0]          cnt_q;
        logic [CW-1:0]          cnt_d;
        logic                   deb_q;
        logic                   deb_d;
        logic                   upd_c_l;
        logic                   hold_c;
        logic                   mism_c;

        assign mism_c = (sync_q[SYNC_STAGES-1] != deb_q);

`ifdef DEBOUNCE_LOCKOUT_EN
        logic [CW-1:0] lock_q;
        logic [CW-1:0] lock_d;

        // Lockout timer: loaded on each accepted change, then counts down to idle.
        always_comb begin
            lock_d = lock_q;
            if (upd_c_l) begin
                lock_d = CW'(CNT_MAX);
            end else if (lock_q != '0) begin
                lock_d = lock_q - CW'(1);
            end
        end

        assign hold_c = (lock_q != '0);

        // Lockout timer register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lock_q <= '0;
            end else begin
                lock_q <= lock_d;
            end
        end
`else
        assign hold_c = 1'b0;
`endif

        // Synchronizer shift: raw enters stage 0, last stage is the clean level.
        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], raw_c[g]};
        end

        // Stability counter: accept the new level after CNT_MAX mismatching cycles.
        always_comb begin
            cnt_d   = '0;
            deb_d   = deb_q;
            upd_c_l = 1'b0;
            if (hold_c || !mism_c) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                deb_d   = sync_q[SYNC_STAGES-1];
                upd_c_l = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Per-channel state registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_q <= '0;
                cnt_q  <= '0;
                deb_q  <= 1'b0;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                deb_q  <= deb_d;
            end
        end

        assign sync_c[g] = sync_q[SYNC_STAGES-1];
        assign deb_c[g]  = deb_q;
        assign upd_c[g]  = upd_c_l;
    end

    // One pulse per edge on which either channel accepted a change.
    always_comb begin
        chg_d = |upd_c;
    end

    // Change pulse register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign deb_1 = deb_c[0];
    assign deb_2 = deb_c[1];
    assign chg   = chg_q;
    assign busy  = |(sync_c ^ deb_c);

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
// Directed scenarios plus randomized hold-length stimulus, every cycle checked
// against a window-based reference model of the debouncer.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int unsigned CNT_MAX     = 4;
    localparam int unsigned SYNC_STAGES = 2;
`ifdef DEBOUNCE_LOCKOUT_EN
    localparam int LOCK = CNT_MAX;
`else
    localparam int LOCK = 0;
`endif
    localparam int HMAX = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic raw_1 = 1'b0;
    logic raw_2 = 1'b0;
    logic deb_1;
    logic deb_2;
    logic chg;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    input_debouncer #(
        .CNT_MAX     (CNT_MAX),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_1 (raw_1),
        .raw_2 (raw_2),
        .deb_1 (deb_1),
        .deb_2 (deb_2),
        .chg   (chg),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference model state: edge counter, per-edge synchronized level history,
    // raw delay line, accepted level and edge of the last accept/reset event.
    int   edge_n = 0;
    logic sync_hist [2][0:HMAX-1];
    logic [SYNC_STAGES-1:0] dly [2];
    logic deb_m [2];
    int   last_evt [2];
    int   lock_m [2];
    logic chg_m  = 1'b0;
    logic busy_m = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // A channel accepts a new level on edge n when the synchronized level seen
    // on each of the previous CNT_MAX edges differed from the accepted level and
    // no accept/reset happened within that window (plus lockout when enabled).
    task automatic model_edge(input logic r, input logic a, input logic b);
        logic rw [2];
        logic any;
        logic ok;
        rw[0] = a;
        rw[1] = b;
        edge_n++;
        any = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            if (!r) begin
                dly[ch]              = '0;
                deb_m[ch]            = 1'b0;
                last_evt[ch]         = edge_n;
                lock_m[ch]           = 0;
                sync_hist[ch][edge_n] = 1'b0;
            end else begin
                ok = (edge_n - last_evt[ch] >= CNT_MAX + lock_m[ch]);
                if (ok) begin
                    for (int k = 1; k <= CNT_MAX; k++) begin
                        if (sync_hist[ch][edge_n-k] == deb_m[ch]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    deb_m[ch]    = ~deb_m[ch];
                    last_evt[ch] = edge_n;
                    lock_m[ch]   = LOCK;
                    any          = 1'b1;
                end
                dly[ch] = {dly[ch][SYNC_STAGES-2:0], rw[ch]};
                sync_hist[ch][edge_n] = dly[ch][SYNC_STAGES-1];
            end
        end
        chg_m  = any;
        busy_m = (sync_hist[0][edge_n] != deb_m[0]) | (sync_hist[1][edge_n] != deb_m[1]);
    endtask

    // Drive inputs away from the edge, advance one edge, check all outputs.
    task automatic step(input logic r, input logic a, input logic b);
        @(negedge clk);
        rst_n = r;
        raw_1 = a;
        raw_2 = b;
        @(posedge clk);
        model_edge(r, a, b);
        #1;
        check("deb_1", int'(deb_1), int'(deb_m[0]));
        check("deb_2", int'(deb_2), int'(deb_m[1]));
        check("chg",   int'(chg),   int'(chg_m));
        check("busy",  int'(busy),  int'(busy_m));
    endtask

    initial begin
        int lat;
        int lat2;
        int pulses;
        int seen;
        int hold;
        logic a;
        logic b;
        logic r;

        // Reset with both raw inputs high: everything reads 0.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        check("rst_deb_1", int'(deb_1), 0);
        check("rst_deb_2", int'(deb_2), 0);
        check("rst_chg",   int'(chg),   0);
        check("rst_busy",  int'(busy),  0);

        // Release: both channels rise on edge SYNC_STAGES+CNT_MAX, one chg pulse.
        lat = 0; lat2 = 0; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 1'b1);
            if (deb_1 && lat == 0) lat = k;
            if (deb_2 && lat2 == 0) lat2 = k;
            if (chg) pulses++;
        end
        check("release_lat_1", lat, 6);
        check("release_lat_2", lat2, 6);
        check("release_pulses", pulses, 1);

        // Bring both channels back to 0.
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);
        check("low_deb_1", int'(deb_1), 0);

        // Clean step on channel 1; channel 2 must stay 0.
        lat = 0; seen = 0; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (deb_1 && lat == 0) lat = k;
            if (deb_2) seen = 1;
            if (chg) pulses++;
        end
        check("step_lat_1", lat, 6);
        check("step_deb_2_quiet", seen, 0);
        check("step_pulses", pulses, 1);

        // Glitch of CNT_MAX-1 cycles on channel 2 is rejected.
        seen = 0; pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1);
            if (deb_2) seen = 1;
            if (chg) pulses++;
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (deb_2) seen = 1;
            if (chg) pulses++;
        end
        check("glitch3_deb_2", seen, 0);
        check("glitch3_chg", pulses, 0);

        // Glitch of CNT_MAX cycles is accepted.
        seen = 0;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (deb_2) seen = 1;
        end
        check("glitch4_deb_2", seen, 1);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);

        // Simultaneous rise: same edge, single pulse.
        lat = 0; lat2 = 0; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 1'b1);
            if (deb_1 && lat == 0) lat = k;
            if (deb_2 && lat2 == 0) lat2 = k;
            if (chg) pulses++;
        end
        check("simul_lat_1", lat, 6);
        check("simul_lat_2", lat2, 6);
        check("simul_pulses", pulses, 1);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);

        // Reset in the middle of a count discards it.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("midrst_deb_1", int'(deb_1), 0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (deb_1 && lat == 0) lat = k;
        end
        check("midrst_lat_1", lat, 6);

        // Drop right after a rise: lockout delays the fall when enabled.
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (deb_1) seen = 1;
        end
        check("drop_rise_seen", seen, 1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (!deb_1 && lat == 0) lat = k;
        end
        check("drop_fall_lat", lat, (LOCK != 0) ? 2 * CNT_MAX : SYNC_STAGES + CNT_MAX);

        // Randomized hold lengths with occasional resets.
        a = 1'b0; b = 1'b0;
        for (int seg = 0; seg < 600; seg++) begin
            if ($urandom_range(0, 1) == 1) a = ~a;
            if ($urandom_range(0, 1) == 1) b = ~b;
            r = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            hold = int'($urandom_range(1, 8));
            for (int k = 0; k < hold; k++) begin
                step((k == 0) ? r : 1'b1, a, b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
